// File: rtl/serdes_deserializer.sv
// -----------------------------------------------------------------------------
// serdes_deserializer
//
// Gathers N_SAMPLES serial words of BIT_WIDTH bits into one parallel frame.
// It uses valid/ready handshakes on both sides. A transfer happens only when
// val and rdy are both high at a rising clk edge.
//
// Operation:
//   COLLECT : recv_rdy=1 and send_val=0. Each accepted word goes into
//             slot[cnt], and cnt then advances. When the last slot is
//             written, cnt wraps to 0 and the block moves to OUTPUT.
//   OUTPUT  : send_val=1 and the slots hold their values. A send transfer
//             returns the block to COLLECT.
//   With N_SAMPLES==1 the block is a purely combinational pass-through.
//
// Optional feature (macro SERDES_DESERIALIZER_OVERLAP_EN):
//   In OUTPUT, recv_rdy follows send_rdy combinationally. A send transfer and
//   a recv transfer in the same cycle write slot[0] and set cnt to 1. This
//   lets back-to-back frames flow with no idle cycle between them.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   recv_msg  in   [BIT_WIDTH-1:0] serial sample word
//   recv_val  in   recv_msg valid
//   recv_rdy  out  block can accept recv_msg
//   send_msg  out  [BIT_WIDTH-1:0] x N_SAMPLES parallel frame, index 0 = first word
//   send_val  out  send_msg holds a complete frame
//   send_rdy  in   downstream accepts the frame
// -----------------------------------------------------------------------------
module serdes_deserializer #(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] recv_msg,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_msg [0:N_SAMPLES-1],
   output logic                 send_val,
   input  logic                 send_rdy
);

   generate
      if (N_SAMPLES == 1) begin : g_pass
         // No state is needed; the clock and reset are folded into a dummy net
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ reset;

         assign send_msg[0] = recv_msg;
         assign send_val    = recv_val;
         assign recv_rdy    = send_rdy;
      end else begin : g_fsm
         localparam int CW = $clog2(N_SAMPLES);
         localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

         typedef enum logic {ST_COLLECT = 1'b0, ST_OUTPUT = 1'b1} state_t;

         state_t               state;
         state_t               state_next;
         logic [CW-1:0]        cnt;
         logic [CW-1:0]        cnt_next;
         logic [CW-1:0]        wr_idx;
         logic                 wr_en;
         logic                 recv_xfer;
         logic                 send_xfer;
         logic [BIT_WIDTH-1:0] slot [0:N_SAMPLES-1];

         // Ready is low during reset and in OUTPUT (overlap mode: follows send_rdy)
         always_comb begin
            recv_rdy = 1'b0;
            if (reset) begin
               recv_rdy = 1'b0;
            end else if (state == ST_COLLECT) begin
               recv_rdy = 1'b1;
            end else begin
`ifdef SERDES_DESERIALIZER_OVERLAP_EN
               recv_rdy = send_rdy;
`else
               recv_rdy = 1'b0;
`endif
            end
         end

         assign send_val  = (state == ST_OUTPUT);
         assign recv_xfer = recv_val & recv_rdy;
         assign send_xfer = send_val & send_rdy;
         assign send_msg  = slot;

         // Next-state, counter and slot-write decode
         always_comb begin
            state_next = state;
            cnt_next   = cnt;
            wr_en      = 1'b0;
            wr_idx     = cnt;
            case (state)
               ST_COLLECT: begin
                  if (recv_xfer) begin
                     wr_en = 1'b1;
                     if (cnt == LAST) begin
                        cnt_next   = {CW{1'b0}};
                        state_next = ST_OUTPUT;
                     end else begin
                        cnt_next = cnt + CW'(1);
                     end
                  end else begin
                     cnt_next = cnt;
                  end
               end
               ST_OUTPUT: begin
                  // The counter always stays 0 while the frame is presented
                  cnt_next = {CW{1'b0}};
                  if (send_xfer && recv_xfer) begin
                     // Only reachable in overlap mode: first word of the next frame
                     wr_en      = 1'b1;
                     wr_idx     = {CW{1'b0}};
                     cnt_next   = CW'(1);
                     state_next = ST_COLLECT;
                  end else if (send_xfer) begin
                     state_next = ST_COLLECT;
                  end else begin
                     state_next = ST_OUTPUT;
                  end
               end
               default: begin
                  state_next = ST_COLLECT;
                  cnt_next   = {CW{1'b0}};
               end
            endcase
         end

         // State and sample counter registers
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state <= ST_COLLECT;
               cnt   <= {CW{1'b0}};
            end else begin
               state <= state_next;
               cnt   <= cnt_next;
            end
         end

         // Frame slots: cleared by reset, written only on a recv transfer
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < N_SAMPLES; i++) begin
                  slot[i] <= {BIT_WIDTH{1'b0}};
               end
            end else if (wr_en) begin
               slot[wr_idx] <= recv_msg;
            end
         end
      end
   endgenerate

endmodule
